matrix_elementwise: RTL and testbench

MATRIX_ELEMENTWISE -- requirements
Module: matrix_elementwise

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_ew_lane.sv | 58 +++++
 rtl/matrix_elementwise.sv | 138 +++++++++++++
 tb/tb_matrix_elementwise.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the element-wise matrix engine: operation modes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package matrix_pkg;

    // Operation select, encoded exactly as driven on the mode port.
    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_MAX = 2'b10,
        MODE_MIN = 2'b11
    } mode_t;

    // Job sequencing states of the top-level controller.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/matrix_ew_lane.sv
// One combinational element operation (add/sub/max/min) on unsigned DW-bit operands.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; result follows inputs.
//
// Ports:
//   mode  - operation select (matrix_pkg::mode_t encoding)
//   a, b  - unsigned operand elements
//   r     - DW+1 bit result (sum, two's complement difference, or zero-extended max/min)
//   clamp - high when the result was clamped (only with MATRIX_EW_SAT_EN, else 0)
// Optional feature macro: MATRIX_EW_SAT_EN clamps add/sub to [0, 2^DW-1].
module matrix_ew_lane
    import matrix_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   r,
    output logic          clamp
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    // One extra bit holds the carry on add and the borrow (sign) on sub.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        r     = '0;
        clamp = 1'b0;
        case (mode_t'(mode))
            MODE_ADD: begin
                r = sum;
`ifdef MATRIX_EW_SAT_EN
                if (sum[DW]) begin
                    r     = {1'b0, {DW{1'b1}}};
                    clamp = 1'b1;
                end
`endif
            end
            MODE_SUB: begin
                r = diff;
`ifdef MATRIX_EW_SAT_EN
                if (a < b) begin
                    r     = '0;
                    clamp = 1'b1;
                end
`endif
            end
            MODE_MAX: r = (a > b) ? {1'b0, a} : {1'b0, b};
            MODE_MIN: r = (a < b) ? {1'b0, a} : {1'b0, b};
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/matrix_elementwise.sv
// Element-wise add/sub/max/min of two captured NxN matrices, LANES elements per cycle.
// Latency: N*N/LANES+1 cycles from the start-sampling edge to the done cycle.
// Backpressure: none; start is honoured only in IDLE, ignored (not queued) while busy.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   start, mode  - job request and operation (00 add, 01 sub, 10 max, 11 min)
//   a, b         - NxN operand matrices of unsigned DW-bit elements, captured on start
//   c            - registered NxN result matrix, DW+1 bits per element
//   busy, done   - busy in RUN/DONE, done is a one-cycle pulse in DONE
//   sat          - sticky per-job saturation flag
// Optional feature macro: MATRIX_EW_SAT_EN (clamping add/sub, sat flag active).
module matrix_elementwise
    import matrix_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [N-1:0][N-1:0][DW-1:0]  a,
    input  logic [N-1:0][N-1:0][DW-1:0]  b,
    output logic [N-1:0][N-1:0][DW:0]    c,
    output logic                         busy,
    output logic                         done,
    output logic                         sat
);

    localparam int NE    = N * N;
    localparam int BEATS = NE / LANES;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EW    = $clog2(NE);

    // Matrices are kept flat, row-major: element [i][j] sits at index i*N+j,
    // which is exactly how the packed port arrays are laid out.
    state_t                      state;
    logic [IW-1:0]               idx;
    logic [NE-1:0][DW-1:0]       a_q;
    logic [NE-1:0][DW-1:0]       b_q;
    logic [1:0]                  mode_q;
    logic [NE-1:0][DW:0]         c_q;
    logic                        sat_q;

    logic [LANES-1:0][EW-1:0]    eidx;
    logic [LANES-1:0][DW-1:0]    la;
    logic [LANES-1:0][DW-1:0]    lb;
    logic [LANES-1:0][DW:0]      lr;
    logic [LANES-1:0]            lclamp;

    // Lane l of beat idx handles the consecutive element idx*LANES+l.
    always_comb begin
        eidx = '0;
        la   = '0;
        lb   = '0;
        for (int l = 0; l < LANES; l++) begin
            eidx[l] = EW'(int'(idx) * LANES + l);
            la[l]   = a_q[eidx[l]];
            lb[l]   = b_q[eidx[l]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        matrix_ew_lane #(
            .DW (DW)
        ) u_lane (
            .mode  (mode_q),
            .a     (la[g]),
            .b     (lb[g]),
            .r     (lr[g]),
            .clamp (lclamp[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 2'b00;
            c_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        sat_q  <= 1'b0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Only the elements of this beat are written; the rest of
                    // c keeps whatever it held before (previous job or reset).
                    for (int l = 0; l < LANES; l++) begin
                        c_q[eidx[l]] <= lr[l];
                    end
                    if (|lclamp) begin
                        sat_q <= 1'b1;
                    end
                    if (idx == IW'(BEATS - 1)) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign c   = c_q;
    // Without the clamping feature no lane ever reports a clamp, so this
    // register never leaves zero.
    assign sat = sat_q;

endmodule

// File: tb/tb_matrix_elementwise.sv
// Self-checking bench: a 4-lane and a 1-lane instance share stimulus and are
// tracked by a job-level model; directed literals pin the model's expectations.
module tb_matrix_elementwise;

    localparam int NE = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  start;
    logic [1:0]            mode;
    logic [NE-1:0][DW-1:0] a_f;
    logic [NE-1:0][DW-1:0] b_f;
    logic [NE-1:0][DW:0]   c0;
    logic [NE-1:0][DW:0]   c1;
    logic                  busy0, done0, sat0;
    logic                  busy1, done1, sat1;

    matrix_elementwise #(.N(4), .DW(8), .LANES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a_f),
        .b     (b_f),
        .c     (c0),
        .busy  (busy0),
        .done  (done0),
        .sat   (sat0)
    );

    matrix_elementwise #(.N(4), .DW(8), .LANES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a_f),
        .b     (b_f),
        .c     (c1),
        .busy  (busy1),
        .done  (done1),
        .sat   (sat1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int ref_elem(input int md, input int x, input int y);
        int r;
        case (md)
            0:       r = x + y;
            1:       r = (x - y) & 511;
            2:       r = (x > y) ? x : y;
            default: r = (x < y) ? x : y;
        endcase
`ifdef MATRIX_EW_SAT_EN
        if (md == 0 && r > 255) r = 255;
        if (md == 1 && x < y)   r = 0;
`endif
        return r;
    endfunction

    function automatic bit ref_clamp(input int md, input int x, input int y);
`ifdef MATRIX_EW_SAT_EN
        return (md == 0 && x + y > 255) || (md == 1 && x < y);
`else
        return (md < 0) && (x < y);
`endif
    endfunction

    function automatic int beats_of(input int u);
        return (u == 0) ? 4 : 16;
    endfunction

    function automatic int lanes_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // ---------------- job-level model ----------------
    // m_k: 0 = idle, k>0 = k-th cycle after the start-sampling edge.
    // In cycle k, (k-1) beats have landed; done is the cycle after the last beat.
    int m_old[2][NE];
    int m_new[2][NE];
    bit m_cl[2][NE];
    int m_k[2];
    bit m_sat_hold[2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_k[u] = 0;
            m_sat_hold[u] = 1'b0;
            for (int e = 0; e < NE; e++) begin
                m_old[u][e] = 0; m_new[u][e] = 0; m_cl[u][e] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    m_k[u] = 0;
                    m_sat_hold[u] = 1'b0;
                    for (int e = 0; e < NE; e++) begin
                        m_old[u][e] = 0; m_new[u][e] = 0; m_cl[u][e] = 1'b0;
                    end
                end else if (m_k[u] == 0) begin
                    if (start) begin
                        for (int e = 0; e < NE; e++) begin
                            m_new[u][e] = ref_elem(int'(mode), int'(a_f[e]), int'(b_f[e]));
                            m_cl[u][e]  = ref_clamp(int'(mode), int'(a_f[e]), int'(b_f[e]));
                        end
                        m_k[u] = 1;
                    end
                end else begin
                    m_k[u]++;
                    if (m_k[u] == beats_of(u) + 2) begin
                        m_k[u] = 0;
                        m_sat_hold[u] = 1'b0;
                        for (int e = 0; e < NE; e++) begin
                            m_old[u][e] = m_new[u][e];
                            if (m_cl[u][e]) m_sat_hold[u] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        logic [NE-1:0][DW:0] ev;
        int  w;
        bit  es;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int u = 0; u < 2; u++) begin
                    if (m_k[u] == 0) begin
                        w = 0;
                    end else begin
                        w = ((m_k[u] - 1 < beats_of(u)) ? m_k[u] - 1 : beats_of(u)) * lanes_of(u);
                    end
                    es = (m_k[u] == 0) ? m_sat_hold[u] : 1'b0;
                    for (int e = 0; e < NE; e++) begin
                        ev[e] = (e < w) ? 9'(m_new[u][e]) : 9'(m_old[u][e]);
                        if (e < w && m_cl[u][e]) es = 1'b1;
                    end
                    check($sformatf("c%0d", u), 144'(u == 0 ? c0 : c1), 144'(ev));
                    check($sformatf("busy%0d", u), 144'(u == 0 ? busy0 : busy1), 144'(m_k[u] > 0));
                    check($sformatf("done%0d", u), 144'(u == 0 ? done0 : done1),
                          144'(m_k[u] == beats_of(u) + 1));
                    check($sformatf("sat%0d", u), 144'(u == 0 ? sat0 : sat1), 144'(es));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy0 && !busy1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("wait_idle_timeout", 144'(1), 144'(0));
    endtask

    // Called at a negedge: raises start for one sampling edge and returns the
    // cycle number (1 = cycle right after the start edge) in which done is seen.
    task automatic go_and_wait(input int u, input logic [1:0] md, output int lat);
        mode  = md;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if ((u == 0) ? done0 : done1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 144'(1), 144'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int dcnt;
        int ix;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        a_f   = '0;
        b_f   = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_c0", 144'(c0), 144'(0));
        check("reset_busy0", 144'(busy0), 144'(0));
        check("reset_done0", 144'(done0), 144'(0));
        check("reset_sat0", 144'(sat0), 144'(0));
        rst = 1'b0;
        @(negedge clk);

        // add, all 255 + 255
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'd255; b_f[e] = 8'd255; end
        go_and_wait(0, 2'b00, lat);
        check("add_latency", 144'(lat), 144'(5));
`ifdef MATRIX_EW_SAT_EN
        check("add_c00", 144'(c0[0]), 144'(255));
        check("add_c33", 144'(c0[15]), 144'(255));
        check("add_sat", 144'(sat0), 144'(1));
`else
        check("add_c00", 144'(c0[0]), 144'(510));
        check("add_c33", 144'(c0[15]), 144'(510));
        check("add_sat", 144'(sat0), 144'(0));
`endif
        wait_idle();

        // sub, 0 - 1
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'd0; b_f[e] = 8'd1; end
        go_and_wait(0, 2'b01, lat);
`ifdef MATRIX_EW_SAT_EN
        check("sub_c11", 144'(c0[5]), 144'(0));
        check("sub_sat", 144'(sat0), 144'(1));
`else
        check("sub_c11", 144'(c0[5]), 144'(9'h1FF));
        check("sub_sat", 144'(sat0), 144'(0));
`endif
        wait_idle();

        // max / min with a = i*4+j, b = 15-a
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'(e); b_f[e] = 8'(15 - e); end
        go_and_wait(0, 2'b10, lat);
        check("max_c00", 144'(c0[0]), 144'(15));
        check("max_c12", 144'(c0[6]), 144'(9));
        wait_idle();
        go_and_wait(0, 2'b11, lat);
        check("min_c12", 144'(c0[6]), 144'(6));
        check("min_c33", 144'(c0[15]), 144'(0));
        wait_idle();

        // start re-asserted mid-RUN with new operands must be ignored
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'(e * 10); b_f[e] = 8'(e); end
        mode  = 2'b00;
        start = 1'b1;
        dcnt  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                for (int e = 0; e < NE; e++) a_f[e] = 8'd255;
                start = 1'b1;
            end
            if (done0) dcnt++;
        end
        check("restart_done_count", 144'(dcnt), 144'(1));
        check("restart_c03", 144'(c0[3]), 144'(33));
        check("restart_c33", 144'(c0[15]), 144'(165));
        wait_idle();

        // reset during RUN cycle 2 aborts the job
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'(e); b_f[e] = 8'(e); end
        mode  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_c0", 144'(c0), 144'(0));
        check("abort_busy0", 144'(busy0), 144'(0));
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done0) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", 144'(dcnt), 144'(0));
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'(e); b_f[e] = 8'd1; end
        go_and_wait(0, 2'b01, lat);
        check("after_abort_latency", 144'(lat), 144'(5));
        check("after_abort_c10", 144'(c0[4]), 144'(3));
        wait_idle();

        // single-lane instance latency
        for (int e = 0; e < NE; e++) begin a_f[e] = 8'd1; b_f[e] = 8'd2; end
        go_and_wait(1, 2'b00, lat);
        check("lane1_latency", 144'(lat), 144'(17));
        check("lane1_c33", 144'(c1[15]), 144'(3));

        // random add jobs on the single-lane instance
        for (int j = 0; j < 1000; j++) begin
            wait_idle();
            for (int e = 0; e < NE; e++) begin
                a_f[e] = 8'($urandom_range(0, 255));
                b_f[e] = 8'($urandom_range(0, 255));
            end
            go_and_wait(1, 2'b00, lat);
            ix = j % NE;
            check("rand_add", 144'(c1[ix]), 144'(ref_elem(0, int'(a_f[ix]), int'(b_f[ix]))));
        end
        wait_idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
